// File: rtl/scoreboard_regfile_pkg.sv
// Shared core types: register-file sizing defaults, architectural register address
// and the micro-op value type carried on read/write ports.
package scoreboard_regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_AW        = $clog2(NREGS_DEFAULT);

    typedef logic [REG_AW-1:0]       reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] uop_val_t;

endpackage

// File: rtl/scoreboard_regfile_wr_arbiter.sv
// Per-register write-port resolution: highest-index enabled port targeting a
// register wins its data and clear flag. Register 0 never registers a hit.
module regfile_wr_arbiter
    import scoreboard_regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic [NWRITE-1:0]           wr_en,
    input  logic [NWRITE-1:0][AW-1:0]   wr_addr,
    input  logic [NWRITE-1:0][XLEN-1:0] wr_data,
    input  logic [NWRITE-1:0]           wr_clr,
    output logic [NREGS-1:0]            hit,
    output logic [NREGS-1:0]            clr_hit,
    output logic [NREGS-1:0][XLEN-1:0]  win_data
);

    always_comb begin
        hit      = '0;
        clr_hit  = '0;
        win_data = '0;
        // Ascending port scan: a later match overrides, so the highest index wins.
        for (int r = 1; r < NREGS; r++) begin
            for (int w = 0; w < NWRITE; w++) begin
                if (wr_en[w] && (wr_addr[w] == AW'(r))) begin
                    hit[r]      = 1'b1;
                    clr_hit[r]  = wr_clr[w];
                    win_data[r] = wr_data[w];
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port flip-flop register file with write bypass and a per-register
// pending (in-flight producer) scoreboard plus a registered pending count.
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NWRITE-1:0]           wr_en,
    input  logic [NWRITE-1:0][AW-1:0]   wr_addr,
    input  logic [NWRITE-1:0][XLEN-1:0] wr_data,
    input  logic [NWRITE-1:0]           wr_clr,
    input  logic [NREAD-1:0][AW-1:0]    rd_addr,
    output logic [NREAD-1:0][XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]            rd_busy,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_addr,
    input  logic                        flush,
    output logic [CW-1:0]               busy_count
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           pend_q, pend_d;
    logic [CW-1:0]              busy_count_q, busy_count_d;

    logic [NREGS-1:0]           hit;
    logic [NREGS-1:0]           clr_hit;
    logic [NREGS-1:0][XLEN-1:0] win_data;

    function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    regfile_wr_arbiter #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_arb (
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_clr   (wr_clr),
        .hit      (hit),
        .clr_hit  (clr_hit),
        .win_data (win_data)
    );

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 1; r < NREGS; r++) begin
            if (hit[r]) regs_d[r] = win_data[r];
            // A new producer outranks the retiring one, flush outranks both.
            if (flush)                                      pend_d[r] = 1'b0;
            else if (alloc_en && (alloc_addr == AW'(r)))    pend_d[r] = 1'b1;
            else if (hit[r] && clr_hit[r])                  pend_d[r] = 1'b0;
        end
        regs_d[0]    = '0;
        pend_d[0]    = 1'b0;
        busy_count_d = popcount(pend_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '0;
            pend_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            pend_q       <= pend_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i] = hit[rd_addr[i]] ? win_data[rd_addr[i]] : regs_q[rd_addr[i]];
            rd_busy[i] = pend_q[rd_addr[i]] & ~(hit[rd_addr[i]] & clr_hit[rd_addr[i]]);
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: a vector table stepped one cycle per entry,
// then a hand-written asynchronous reset sequence.
module tb_scoreboard_regfile;
    import scoreboard_regfile_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           wr_en;
    logic [1:0][4:0]      wr_addr;
    logic [1:0][31:0]     wr_data;
    logic [1:0]           wr_clr;
    logic [1:0][4:0]      rd_addr;
    logic [1:0][31:0]     rd_data;
    logic [1:0]           rd_busy;
    logic                 alloc_en;
    logic [4:0]           alloc_addr;
    logic                 flush;
    logic [5:0]           busy_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] we;
        reg_addr_t  a0;
        uop_val_t   d0;
        reg_addr_t  a1;
        uop_val_t   d1;
        logic [1:0] clr;
        reg_addr_t  ra0;
        reg_addr_t  ra1;
        logic       al;
        reg_addr_t  aa;
        logic       fl;
        uop_val_t   e0;
        uop_val_t   e1;
        logic [1:0] eb;
        logic [5:0] ec;
    } vec_t;

    vec_t vecs[$];

    scoreboard_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_clr     (wr_clr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input reg_addr_t a0, input uop_val_t d0,
                         input reg_addr_t a1, input uop_val_t d1, input logic [1:0] clr,
                         input reg_addr_t ra0, input reg_addr_t ra1,
                         input logic al, input reg_addr_t aa, input logic fl);
        wr_en      = we;
        wr_addr    = {a1, a0};
        wr_data    = {d1, d0};
        wr_clr     = clr;
        rd_addr    = {ra1, ra0};
        alloc_en   = al;
        alloc_addr = aa;
        flush      = fl;
    endtask

    task automatic idle(input reg_addr_t ra0, input reg_addr_t ra1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, ra0, ra1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic add(input logic [1:0] we, input reg_addr_t a0, input uop_val_t d0,
                       input reg_addr_t a1, input uop_val_t d1, input logic [1:0] clr,
                       input reg_addr_t ra0, input reg_addr_t ra1,
                       input logic al, input reg_addr_t aa, input logic fl,
                       input uop_val_t e0, input uop_val_t e1,
                       input logic [1:0] eb, input logic [5:0] ec);
        vec_t v;
        v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.clr = clr;
        v.ra0 = ra0; v.ra1 = ra1; v.al = al; v.aa = aa; v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
        vecs.push_back(v);
    endtask

    initial begin
        // Each entry: inputs held for one cycle; expectations sampled before its edge.
        //   we     a0    d0            a1    d1       clr    ra0   ra1   al    aa    fl    e0            e1        eb     ec
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0,    2'b00, 6'd0);
        add(2'b11, 5'd3, 32'h11,       5'd3, 32'h22,  2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 32'h22,       32'h22,   2'b00, 6'd0);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 32'h22,       32'h0,    2'b00, 6'd0);
        add(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,   2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0,        32'h0,    2'b00, 6'd0);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0, 32'h0,        32'h0,    2'b00, 6'd0);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0,    2'b01, 6'd1);
        add(2'b10, 5'd0, 32'h0,        5'd7, 32'h5A,  2'b10, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'h5A,       32'h5A,   2'b00, 6'd1);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h5A,       32'h0,    2'b00, 6'd0);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 32'h0,        32'h0,    2'b00, 6'd0);
        add(2'b01, 5'd9, 32'h99,       5'd0, 32'h0,   2'b01, 5'd9, 5'd7, 1'b1, 5'd9, 1'b0, 32'h99,       32'h5A,   2'b00, 6'd1);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 32'h99,       32'h99,   2'b11, 6'd1);
        add(2'b01, 5'd9, 32'h77,       5'd0, 32'h0,   2'b00, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0, 32'h77,       32'h22,   2'b01, 6'd1);
        add(2'b11, 5'd9, 32'h1,        5'd9, 32'h2,   2'b01, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 32'h2,        32'h2,    2'b11, 6'd1);
        add(2'b11, 5'd9, 32'h4,        5'd9, 32'h3,   2'b10, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0, 32'h3,        32'h22,   2'b00, 6'd1);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd1, 5'd9, 1'b1, 5'd1, 1'b0, 32'h0,        32'h3,    2'b00, 6'd0);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0, 32'h0,        32'h0,    2'b01, 6'd1);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd2, 5'd4, 1'b1, 5'd4, 1'b0, 32'h0,        32'h0,    2'b01, 6'd2);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd4, 5'd6, 1'b1, 5'd6, 1'b1, 32'h0,        32'h0,    2'b01, 6'd3);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,   2'b00, 5'd6, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0,    2'b00, 6'd0);

        rst_n = 1'b0;
        idle(5'd5, 5'd5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1, vecs[i].clr,
                  vecs[i].ra0, vecs[i].ra1, vecs[i].al, vecs[i].aa, vecs[i].fl);
            #1;
            check($sformatf("v%0d rd_data0", i), rd_data[0], vecs[i].e0);
            check($sformatf("v%0d rd_data1", i), rd_data[1], vecs[i].e1);
            check($sformatf("v%0d rd_busy", i), 32'(rd_busy), 32'(vecs[i].eb));
            check($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(vecs[i].ec));
            @(negedge clk);
        end

        // Mid-cycle asynchronous reset with pending state and stored data present.
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0);
        @(negedge clk);
        idle(5'd3, 5'd5);
        #1;
        check("pre_rst rd_data0", rd_data[0], 32'h22);
        check("pre_rst rd_busy1", 32'(rd_busy[1]), 32'd1);
        check("pre_rst busy_count", 32'(busy_count), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst rd_data0", rd_data[0], 32'h0);
        check("rst rd_busy", 32'(rd_busy), 32'd0);
        check("rst busy_count", 32'(busy_count), 32'd0);
        drive(2'b01, 5'd8, 32'hAB, 5'd0, 32'h0, 2'b00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0);
        #1;
        check("rst bypass rd_data0", rd_data[0], 32'hAB);
        check("rst bypass rd_data1", rd_data[1], 32'h0);
        @(negedge clk);
        idle(5'd8, 5'd8);
        #1;
        check("rst held rd_data0", rd_data[0], 32'h0);
        check("rst held busy_count", 32'(busy_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0);
        @(negedge clk);
        idle(5'd8, 5'd3);
        #1;
        check("post_rst rd_busy0", 32'(rd_busy[0]), 32'd1);
        check("post_rst rd_data1", rd_data[1], 32'h0);
        check("post_rst busy_count", 32'(busy_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
